// File: rtl/present_round_ctrl.sv
// present_round_ctrl: iterative PRESENT-80 encryption engine, one round per clock.
// Ports:
//    clock      rising-edge clock
//    reset      synchronous active-high reset
//    start_in   start request, sampled only while busy is low
//    plaintext  64-bit block, captured with start_in
//    key_in     80-bit cipher key, captured with start_in
//    busy       high while a block is in flight
//    done       one-cycle strobe marking out as fresh
//    round_out  current round counter
//    out        ciphertext, held until the next completed block
module present_round_ctrl #(
   parameter int ROUNDS = 31
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_in,
   input  logic [63:0] plaintext,
   input  logic [79:0] key_in,
   output logic        busy,
   output logic        done,
   output logic [4:0]  round_out,
   output logic [63:0] out
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;
   localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
   function automatic logic [63:0] sbox_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[4*i +: 4] = SBOX[x[4*i +: 4]];
      return y;
   endfunction
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
      y[63] = x[63];
      return y;
   endfunction
   fsm_t        fsm, fsm_nxt;
   logic [63:0] state, rk, state_nxt;
   logic [79:0] keyreg, key_rot, key_nxt;
   logic [4:0]  round;
   assign round_out = round;
   always_comb begin
      rk        = state ^ keyreg[79:16];
      state_nxt = p_layer(sbox_layer(rk));
      // rotate left by 61 is the same as rotate right by 19
      key_rot   = {keyreg[18:0], keyreg[79:19]};
      key_nxt   = {SBOX[key_rot[79:76]], key_rot[75:20], key_rot[19:15] ^ round, key_rot[14:0]};
      fsm_nxt   = fsm == IDLE  ? (start_in ? ROUND : IDLE) :
                  fsm == ROUND ? (round == 5'(ROUNDS) ? FINAL : ROUND) : IDLE;
      busy      = fsm != IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         fsm    <= IDLE;
         state  <= '0;
         keyreg <= '0;
         round  <= '0;
         out    <= '0;
         done   <= 1'b0;
      end else begin
         fsm  <= fsm_nxt;
         done <= fsm == FINAL;
         if (fsm == IDLE && start_in) begin
            state  <= plaintext;
            keyreg <= key_in;
            round  <= 5'd1;
         end else if (fsm == ROUND) begin
            state  <= state_nxt;
            keyreg <= key_nxt;
            round  <= round + 5'd1;
         end else if (fsm == FINAL) begin
            out   <= rk;
            round <= '0;
         end
      end
   end
endmodule

// File: tb/tb_present_round_ctrl.sv
// tb_present_round_ctrl: directed-vector bench for present_round_ctrl using PRESENT-80 reference vectors.
module tb_present_round_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start_in = 1'b0;
   logic [63:0] plaintext = '0;
   logic [79:0] key_in = '0;
   logic        busy, done;
   logic [4:0]  round_out;
   logic [63:0] out;
   int          n_cmp = 0;
   int          n_bad = 0;

   present_round_ctrl #(.ROUNDS(31)) dut (
      .clock(clock), .reset(reset), .start_in(start_in), .plaintext(plaintext),
      .key_in(key_in), .busy(busy), .done(done), .round_out(round_out), .out(out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; issues one start and returns at the negedge where done is seen.
   task automatic run(input string tag, input logic [63:0] pt, input logic [79:0] key,
                      input logic [63:0] exp, input bit noise, input bit trace);
      bit got = 0;
      start_in  = 1'b1;
      plaintext = pt;
      key_in    = key;
      @(posedge clock);
      for (int k = 1; k <= 40 && !got; k++) begin
         @(negedge clock);
         if (done) begin
            start_in = 1'b0;
            got = 1;
            chk({tag, " latency"}, 80'(k), 80'd33);
            chk({tag, " out"}, 80'(out), 80'(exp));
            chk({tag, " busy@done"}, 80'(busy), 80'd0);
            chk({tag, " round@done"}, 80'(round_out), 80'd0);
         end else begin
            if (trace) begin
               chk($sformatf("%s round%0d", tag, k), 80'(round_out), 80'(k <= 31 ? k : 0));
               chk($sformatf("%s busy%0d", tag, k), 80'(busy), 80'd1);
            end
            start_in = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
               plaintext = {$urandom, $urandom};
               key_in    = {16'($urandom), $urandom, $urandom};
            end
         end
      end
      if (!got) chk({tag, " timeout"}, 80'd0, 80'd1);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst busy", 80'(busy), 80'd0);
      chk("rst done", 80'(done), 80'd0);
      chk("rst round", 80'(round_out), 80'd0);
      chk("rst out", 80'(out), 80'd0);
      reset = 1'b0;
      @(negedge clock);

      run("v0", 64'h0, 80'h0, 64'h5579C1387B228445, 0, 1);
      @(negedge clock);
      chk("done strobe", 80'(done), 80'd0);
      chk("out hold", 80'(out), 80'h5579C1387B228445);

      run("v1", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 0);
      run("v2", {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 0, 0);
      run("v3b2b", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 0, 0);

      run("noise", 64'h0, 80'h0, 64'h5579C1387B228445, 1, 1);
      repeat (5) begin
         @(negedge clock);
         chk("no extra done", 80'(done), 80'd0);
         chk("idle busy", 80'(busy), 80'd0);
      end
      chk("out hold2", 80'(out), 80'h5579C1387B228445);

      start_in  = 1'b1;
      plaintext = {64{1'b1}};
      key_in    = 80'h0;
      @(posedge clock);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         start_in = 1'b0;
      end
      chk("pre-rst round", 80'(round_out), 80'd10);
      reset = 1'b1;
      @(negedge clock);
      chk("mid rst busy", 80'(busy), 80'd0);
      chk("mid rst done", 80'(done), 80'd0);
      chk("mid rst out", 80'(out), 80'd0);
      chk("mid rst round", 80'(round_out), 80'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("post rst done", 80'(done), 80'd0);
      run("after rst", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
